// File: rtl/cntl_mc.sv
// ============================================================================
// Module   : cntl_mc
// Purpose  : Multi-cycle RV32I control unit. A FETCH/DECODE/EXEC/MEM/WB state
//            register drives combinational datapath controls decoded from the
//            current state, the instruction word and the latched branch result.
// Option   : CNTL_MC_ILLEGAL_HALT_EN - unknown opcodes lock the unit in HALT
//            (all outputs 0) until reset; otherwise they retire as a NOP.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cntl_mc (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        bcond,
  output logic        sz_ex_sel,
  output logic [1:0]  sz_ex_mode,
  output logic        mem_sz_ex_sel,
  output logic [19:0] imm,
  output logic        mem_sel,
  output logic [1:0]  mem_size,
  output logic        pc_update,
  output logic        load_ir,
  output logic        load_mdr,
  output logic        mem_wr_en,
  output logic        reg_file_wr_en,
  output logic        wr_reg_mux_sel,
  output logic        op1_sel,
  output logic [1:0]  op2_sel,
  output logic [1:0]  alu_demux,
  output logic [4:0]  alu_ctrl
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [4:0] ALU_ADD      = 5'd0;
  localparam logic [4:0] ALU_SUB      = 5'd1;
  localparam logic [4:0] ALU_SLL      = 5'd2;
  localparam logic [4:0] ALU_SLT      = 5'd3;
  localparam logic [4:0] ALU_SLTU     = 5'd4;
  localparam logic [4:0] ALU_XOR      = 5'd5;
  localparam logic [4:0] ALU_SRL      = 5'd6;
  localparam logic [4:0] ALU_SRA      = 5'd7;
  localparam logic [4:0] ALU_OR       = 5'd8;
  localparam logic [4:0] ALU_AND      = 5'd9;
  localparam logic [4:0] ALU_BEQ      = 5'd10;
  localparam logic [4:0] ALU_BNE      = 5'd11;
  localparam logic [4:0] ALU_BLT      = 5'd12;
  localparam logic [4:0] ALU_BGE      = 5'd13;
  localparam logic [4:0] ALU_BLTU     = 5'd14;
  localparam logic [4:0] ALU_BGEU     = 5'd15;
  localparam logic [4:0] ALU_PASS_B   = 5'd16;
  localparam logic [4:0] ALU_JALR_ADD = 5'd17;

  localparam logic [1:0] OP2_RS2  = 2'b00;
  localparam logic [1:0] OP2_IMM  = 2'b01;
  localparam logic [1:0] OP2_FOUR = 2'b10;

  localparam logic [1:0] DST_ALUOUT = 2'b00;
  localparam logic [1:0] DST_PC     = 2'b01;
  localparam logic [1:0] DST_NONE   = 2'b10;

  localparam logic [1:0] IMM_IS = 2'b00;
  localparam logic [1:0] IMM_B  = 2'b01;
  localparam logic [1:0] IMM_U  = 2'b10;
  localparam logic [1:0] IMM_J  = 2'b11;

  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state;
  logic        bcond_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic        is_load, is_store, is_opimm, is_op, is_fence, is_system;
  logic        is_known, writes_rd;
  logic [4:0]  alu_fn, br_fn;
  logic        imm_sign;
  logic [1:0]  imm_mode;
  logic [19:0] imm_raw;

  assign opcode    = inst[6:0];
  assign funct3    = inst[14:12];
  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_opimm  = (opcode == OPC_OPIMM);
  assign is_op     = (opcode == OPC_OP);
  assign is_fence  = (opcode == OPC_FENCE);
  assign is_system = (opcode == OPC_SYSTEM);
  assign is_known  = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load |
                     is_store | is_opimm | is_op | is_fence | is_system;
  assign writes_rd = is_op | is_opimm | is_load | is_lui | is_auipc | is_jal | is_jalr;

  // Arithmetic/logic and branch-compare operation selection from funct3/funct7
  always_comb begin
    alu_fn = ALU_ADD;
    br_fn  = ALU_BEQ;
    case (funct3)
      3'b000:  alu_fn = (is_op && inst[30]) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_fn = ALU_SLL;
      3'b010:  alu_fn = ALU_SLT;
      3'b011:  alu_fn = ALU_SLTU;
      3'b100:  alu_fn = ALU_XOR;
      3'b101:  alu_fn = inst[30] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_fn = ALU_OR;
      default: alu_fn = ALU_AND;
    endcase
    case (funct3)
      3'b001:  br_fn = ALU_BNE;
      3'b100:  br_fn = ALU_BLT;
      3'b101:  br_fn = ALU_BGE;
      3'b110:  br_fn = ALU_BLTU;
      3'b111:  br_fn = ALU_BGEU;
      default: br_fn = ALU_BEQ;
    endcase
  end

  // Immediate extraction; the extender rebuilds the full value from format + mode
  always_comb begin
    imm_raw  = '0;
    imm_mode = IMM_IS;
    imm_sign = 1'b1;
    if (is_lui || is_auipc) begin
      imm_raw  = inst[31:12];
      imm_mode = IMM_U;
      imm_sign = 1'b0;
    end else if (is_jal) begin
      imm_raw  = {inst[31], inst[19:12], inst[20], inst[30:21]};
      imm_mode = IMM_J;
    end else if (is_branch) begin
      imm_raw  = {8'h00, inst[31], inst[7], inst[30:25], inst[11:8]};
      imm_mode = IMM_B;
    end else if (is_store) begin
      imm_raw  = {8'h00, inst[31:25], inst[11:7]};
    end else if (is_load || is_jalr || is_opimm) begin
      imm_raw  = {8'h00, inst[31:20]};
    end
  end

  // State sequencing and branch-outcome capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_FETCH;
      bcond_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          if (is_fence || is_system) begin
            state <= S_WB;
          end else if (!is_known) begin
`ifdef CNTL_MC_ILLEGAL_HALT_EN
            state <= S_HALT;
`else
            state <= S_WB;
`endif
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_branch) bcond_q <= bcond;
          state <= (is_load || is_store) ? S_MEM : S_WB;
        end
        S_MEM:    state <= is_load ? S_WB : S_FETCH;
        S_WB:     state <= S_FETCH;
        S_HALT:   state <= S_HALT;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Datapath controls; reset low or HALT forces every output to zero
  always_comb begin
    sz_ex_sel      = 1'b0;
    sz_ex_mode     = 2'b00;
    mem_sz_ex_sel  = 1'b0;
    imm            = '0;
    mem_sel        = 1'b0;
    mem_size       = 2'b00;
    pc_update      = 1'b0;
    load_ir        = 1'b0;
    load_mdr       = 1'b0;
    mem_wr_en      = 1'b0;
    reg_file_wr_en = 1'b0;
    wr_reg_mux_sel = 1'b0;
    op1_sel        = 1'b0;
    op2_sel        = OP2_RS2;
    alu_demux      = DST_ALUOUT;
    alu_ctrl       = ALU_ADD;
    if (rst && (state != S_HALT)) begin
      sz_ex_sel  = imm_sign;
      sz_ex_mode = imm_mode;
      imm        = imm_raw;
      case (state)
        S_FETCH: begin
          mem_size = SZ_WORD;
          load_ir  = 1'b1;
        end
        S_EXEC: begin
          if (is_op) begin
            alu_ctrl = alu_fn;
          end else if (is_opimm) begin
            op2_sel  = OP2_IMM;
            alu_ctrl = alu_fn;
          end else if (is_load || is_store) begin
            op2_sel  = OP2_IMM;
          end else if (is_lui) begin
            op2_sel  = OP2_IMM;
            alu_ctrl = ALU_PASS_B;
          end else if (is_auipc) begin
            op1_sel  = 1'b1;
            op2_sel  = OP2_IMM;
          end else if (is_jal || is_jalr) begin
            // Link value PC+4 parked in ALUOut for the WB register write
            op1_sel  = 1'b1;
            op2_sel  = OP2_FOUR;
          end else if (is_branch) begin
            alu_demux = DST_NONE;
            alu_ctrl  = br_fn;
          end
        end
        S_MEM: begin
          mem_sel  = 1'b1;
          mem_size = funct3[1:0];
          if (is_store) begin
            // Stores retire here, so the PC advance shares the memory cycle
            mem_wr_en = 1'b1;
            pc_update = 1'b1;
            alu_demux = DST_PC;
            op1_sel   = 1'b1;
            op2_sel   = OP2_FOUR;
          end else begin
            load_mdr      = 1'b1;
            mem_sz_ex_sel = ~funct3[2];
          end
        end
        S_WB: begin
          pc_update = 1'b1;
          alu_demux = DST_PC;
          op1_sel   = 1'b1;
          op2_sel   = OP2_FOUR;
          if (is_jal || (is_branch && bcond_q)) begin
            op2_sel = OP2_IMM;
          end else if (is_jalr) begin
            op1_sel  = 1'b0;
            op2_sel  = OP2_IMM;
            alu_ctrl = ALU_JALR_ADD;
          end
          reg_file_wr_en = writes_rd;
          wr_reg_mux_sel = is_load;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cntl_mc.sv
// ============================================================================
// Module   : tb_cntl_mc
// Purpose  : Scoreboard bench for cntl_mc. A per-instruction reference model
//            expands each instruction into its expected per-cycle control
//            vectors; a monitor pops and compares one vector per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cntl_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst = '0;
  logic        bcond = 1'b0;

  logic        sz_ex_sel, mem_sz_ex_sel, mem_sel, pc_update, load_ir, load_mdr;
  logic        mem_wr_en, reg_file_wr_en, wr_reg_mux_sel, op1_sel;
  logic [1:0]  sz_ex_mode, mem_size, op2_sel, alu_demux;
  logic [19:0] imm;
  logic [4:0]  alu_ctrl;

  cntl_mc dut (
    .clk(clk), .rst(rst), .inst(inst), .bcond(bcond),
    .sz_ex_sel(sz_ex_sel), .sz_ex_mode(sz_ex_mode), .mem_sz_ex_sel(mem_sz_ex_sel),
    .imm(imm), .mem_sel(mem_sel), .mem_size(mem_size), .pc_update(pc_update),
    .load_ir(load_ir), .load_mdr(load_mdr), .mem_wr_en(mem_wr_en),
    .reg_file_wr_en(reg_file_wr_en), .wr_reg_mux_sel(wr_reg_mux_sel),
    .op1_sel(op1_sel), .op2_sel(op2_sel), .alu_demux(alu_demux), .alu_ctrl(alu_ctrl)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sz_ex_sel;
    logic [1:0]  sz_ex_mode;
    logic        mem_sz_ex_sel;
    logic [19:0] imm;
    logic        mem_sel;
    logic [1:0]  mem_size;
    logic        pc_update;
    logic        load_ir;
    logic        load_mdr;
    logic        mem_wr_en;
    logic        reg_file_wr_en;
    logic        wr_reg_mux_sel;
    logic        op1_sel;
    logic [1:0]  op2_sel;
    logic [1:0]  alu_demux;
    logic [4:0]  alu_ctrl;
  } ov_t;

  ov_t act;
  assign act = {sz_ex_sel, sz_ex_mode, mem_sz_ex_sel, imm, mem_sel, mem_size,
                pc_update, load_ir, load_mdr, mem_wr_en, reg_file_wr_en,
                wr_reg_mux_sel, op1_sel, op2_sel, alu_demux, alu_ctrl};

  localparam logic [6:0] O_LUI = 7'h37, O_AUIPC = 7'h17, O_JAL = 7'h6F, O_JALR = 7'h67;
  localparam logic [6:0] O_BR = 7'h63, O_LD = 7'h03, O_ST = 7'h23, O_IMM = 7'h13;
  localparam logic [6:0] O_OP = 7'h33, O_FENCE = 7'h0F, O_SYS = 7'h73;

  // ALU codes by funct3 (base op); SUB/SRA picked by funct7 bit 30
  logic [4:0] rtab [8] = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
  logic [4:0] btab [8] = '{5'd10, 5'd11, 5'd10, 5'd10, 5'd12, 5'd13, 5'd14, 5'd15};
  logic [6:0] opl  [11] = '{O_LUI, O_AUIPC, O_JAL, O_JALR, O_BR, O_LD, O_ST, O_IMM, O_OP, O_FENCE, O_SYS};
  logic [2:0] bf3  [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [2:0] lf3  [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  ov_t   expq[$];
  string tagq[$];
  ov_t   stg[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check_vec(input string name, input ov_t a, input ov_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, a, e);
    end
  endtask

  function automatic bit known(input logic [6:0] o);
    return (o inside {O_LUI, O_AUIPC, O_JAL, O_JALR, O_BR, O_LD, O_ST, O_IMM, O_OP, O_FENCE, O_SYS});
  endfunction

  // Immediate presentation: raw field, format code and extend mode
  function automatic ov_t dec_fields(input logic [31:0] in);
    ov_t v;
    v = '0;
    v.sz_ex_sel = 1'b1;
    case (in[6:0])
      O_LUI, O_AUIPC: begin v.sz_ex_sel = 1'b0; v.sz_ex_mode = 2'd2; v.imm = in[31:12]; end
      O_JAL:          begin v.sz_ex_mode = 2'd3; v.imm = {in[31], in[19:12], in[20], in[30:21]}; end
      O_BR:           begin v.sz_ex_mode = 2'd1; v.imm = {8'h0, in[31], in[7], in[30:25], in[11:8]}; end
      O_ST:           v.imm = {8'h0, in[31:25], in[11:7]};
      O_LD, O_JALR, O_IMM: v.imm = {8'h0, in[31:20]};
      default: ;
    endcase
    return v;
  endfunction

  function automatic ov_t pc_plus4(input ov_t f);
    ov_t c;
    c = f;
    c.pc_update = 1'b1; c.alu_demux = 2'd1; c.op1_sel = 1'b1; c.op2_sel = 2'd2; c.alu_ctrl = 5'd0;
    return c;
  endfunction

  // Reference model: expected vector for every cycle of one instruction
  task automatic model_inst(input logic [31:0] in, input logic b, output bit halted);
    ov_t f, c;
    logic [6:0] opc;
    logic [2:0] f3;
    opc = in[6:0];
    f3  = in[14:12];
    halted = 1'b0;
    stg.delete();
    f = dec_fields(in);
    c = f; c.mem_size = 2'd2; c.load_ir = 1'b1;
    stg.push_back(c);
    stg.push_back(f);
    if (!known(opc) || opc == O_FENCE || opc == O_SYS) begin
`ifdef CNTL_MC_ILLEGAL_HALT_EN
      if (!known(opc)) begin halted = 1'b1; return; end
`endif
      stg.push_back(pc_plus4(f));
      return;
    end
    c = f;
    case (opc)
      O_OP:  c.alu_ctrl = (f3 == 3'd0 && in[30]) ? 5'd1 : (f3 == 3'd5 && in[30]) ? 5'd7 : rtab[f3];
      O_IMM: begin c.op2_sel = 2'd1; c.alu_ctrl = (f3 == 3'd5 && in[30]) ? 5'd7 : rtab[f3]; end
      O_LD, O_ST: c.op2_sel = 2'd1;
      O_LUI:   begin c.op2_sel = 2'd1; c.alu_ctrl = 5'd16; end
      O_AUIPC: begin c.op1_sel = 1'b1; c.op2_sel = 2'd1; end
      O_JAL, O_JALR: begin c.op1_sel = 1'b1; c.op2_sel = 2'd2; end
      O_BR:    begin c.alu_demux = 2'd2; c.alu_ctrl = btab[f3]; end
      default: ;
    endcase
    stg.push_back(c);
    if (opc == O_ST) begin
      c = pc_plus4(f); c.mem_sel = 1'b1; c.mem_wr_en = 1'b1; c.mem_size = f3[1:0];
      stg.push_back(c);
      return;
    end
    if (opc == O_LD) begin
      c = f; c.mem_sel = 1'b1; c.load_mdr = 1'b1; c.mem_size = f3[1:0]; c.mem_sz_ex_sel = !f3[2];
      stg.push_back(c);
    end
    c = pc_plus4(f);
    if (opc == O_JAL || (opc == O_BR && b)) c.op2_sel = 2'd1;
    if (opc == O_JALR) begin c.op1_sel = 1'b0; c.op2_sel = 2'd1; c.alu_ctrl = 5'd17; end
    c.reg_file_wr_en = (opc != O_BR);
    c.wr_reg_mux_sel = (opc == O_LD);
    stg.push_back(c);
  endtask

  // Called one step after a rising edge; holds reset low for cyc cycles
  task automatic do_reset(input int cyc);
    rst = 1'b0;
    for (int i = 0; i < cyc; i++) begin
      expq.push_back('0);
      tagq.push_back($sformatf("in_reset.c%0d", i));
    end
    #1;
    check_vec("reset_immediate", act, '0);
    repeat (cyc) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Issue one instruction from its FETCH cycle; cut>0 resets after cut cycles
  task automatic run_inst(input logic [31:0] in, input logic b, input string nm, input int cut);
    bit halted;
    int n;
    inst = in;
    model_inst(in, b, halted);
    n = (cut > 0) ? cut : stg.size();
    for (int i = 0; i < n; i++) begin
      expq.push_back(stg[i]);
      tagq.push_back($sformatf("%s.c%0d", nm, i));
    end
    for (int c = 0; c < n; c++) begin
      bcond = (c == 2) ? b : 1'($urandom);
      @(posedge clk);
      #1;
    end
    if (halted) begin
      for (int c = 0; c < 3; c++) begin
        expq.push_back('0);
        tagq.push_back($sformatf("%s.halt%0d", nm, c));
        @(posedge clk);
        #1;
      end
      do_reset(1);
    end else if (cut > 0) begin
      do_reset(2);
    end
  endtask

  // Monitor: one expected vector per cycle, sampled on the falling edge
  ov_t   mon_e;
  string mon_t;
  initial begin
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        mon_e = expq.pop_front();
        mon_t = tagq.pop_front();
        check_vec(mon_t, act, mon_e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    int          pick;
    rst   = 1'b0;
    inst  = 32'h002081B3;
    bcond = 1'b1;
    #1;
    check_vec("reset_state", act, '0);
    @(posedge clk);
    #1;
    do_reset(2);

    run_inst(32'h002081B3, 1'b0, "add",        0);
    run_inst(32'h0080A283, 1'b0, "lw",         0);
    run_inst(32'h0050A623, 1'b0, "sw",         0);
    run_inst(32'h00208863, 1'b1, "beq_taken",  0);
    run_inst(32'h00208863, 1'b0, "beq_not",    0);
    run_inst(32'h008000EF, 1'b0, "jal",        0);
    run_inst(32'h002081B3, 1'b0, "add_rst",    2);
    run_inst(32'h0080A283, 1'b0, "lw_post",    0);
    run_inst(32'hFFFFFFFF, 1'b0, "illegal",    0);
    run_inst(32'h0000000F, 1'b0, "fence",      0);
    run_inst(32'h00000073, 1'b0, "ecall",      0);
    run_inst(32'h000280E7, 1'b0, "jalr",       0);
    run_inst(32'h123450B7, 1'b0, "lui",        0);

    for (int k = 0; k < 300; k++) begin
      r    = $urandom;
      pick = $urandom_range(0, 11);
      if (pick == 11) begin
        do r[6:0] = 7'($urandom); while (known(r[6:0]));
      end else begin
        r[6:0] = opl[pick];
        if (r[6:0] == O_BR) r[14:12] = bf3[$urandom_range(0, 5)];
        if (r[6:0] == O_LD) r[14:12] = lf3[$urandom_range(0, 4)];
        if (r[6:0] == O_ST) r[14:12] = 3'($urandom_range(0, 2));
      end
      run_inst(r, 1'($urandom), $sformatf("rnd%0d", k), ($urandom_range(0, 19) == 0) ? 3 : 0);
    end

    repeat (2) @(posedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cntl_mc.md
CNTL_MC -- requirements
Module: cntl_mc

Interface
REQ-001 clk  in  1  rising-edge clock for the state register.
REQ-002 rst  in  1  asynchronous, active-low reset; 0 resets the block immediately.
REQ-003 inst  in  32  instruction from the datapath IR; stable from DECODE onward.
REQ-004 bcond  in  1  ALU compare result from the datapath; valid in EXEC.
REQ-005 sz_ex_sel  out  1  immediate extend mode: 1 = sign-extend, 0 = zero-fill.
REQ-006 sz_ex_mode  out  2  immediate format: 00 = I/S 12b, 01 = B (append 0), 10 = U (shift left 12), 11 = J (append 0).
REQ-007 mem_sz_ex_sel  out  1  load data extend: 1 = sign (LB/LH), 0 = zero (LBU/LHU).
REQ-008 imm  out  20  raw immediate bits, right-justified.
REQ-009 mem_sel  out  1  memory address source: 0 = PC, 1 = ALUOut.
REQ-010 mem_size  out  2  access size: 00 = byte, 01 = half, 10 = word.
REQ-011 pc_update  out  1  PC write enable.
REQ-012 load_ir  out  1  IR write enable.
REQ-013 load_mdr  out  1  MDR write enable.
REQ-014 mem_wr_en  out  1  memory write enable.
REQ-015 reg_file_wr_en  out  1  register-file write enable.
REQ-016 wr_reg_mux_sel  out  1  register write data: 0 = ALUOut, 1 = MDR.
REQ-017 op1_sel  out  1  ALU operand A: 0 = rs1, 1 = PC.
REQ-018 op2_sel  out  2  ALU operand B: 00 = rs2, 01 = extended imm, 10 = constant 4, 11 = zero.
REQ-019 alu_demux  out  2  ALU result destination: 00 = ALUOut, 01 = PC, 10 = none, 11 = reserved.
REQ-020 alu_ctrl  out  5  ALU operation (REQ-024).

Function
REQ-021 The block SHALL use a state register with states FETCH, DECODE, EXEC, MEM and WB; all outputs are combinational from the state, the inst field and bcond_q.
REQ-022 FETCH: mem_sel=0, mem_size=10, load_ir=1, no other enable; next state DECODE. DECODE: no enables; next EXEC, or WB for FENCE/SYSTEM (NOP).
REQ-023 The imm field SHALL be I: inst[31:20]; S: {inst[31:25],inst[11:7]}; B: {inst[31],inst[7],inst[30:25],inst[11:8]}; U: inst[31:12]; J: {inst[31],inst[19:12],inst[20],inst[30:21]}. Unused bits are 0. sz_ex_sel=0 for U-type only.
REQ-024 alu_ctrl SHALL be ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, BEQ 10, BNE 11, BLT 12, BGE 13, BLTU 14, BGEU 15, PASS_B 16, JALR_ADD 17 (sum with bit0 cleared).
REQ-025 EXEC actions (alu_demux=00): R/I-ALU: rs1 op rs2/imm. LOAD/STORE: rs1+imm. LUI: PASS_B with imm. AUIPC/JAL/JALR: writes PC+4, or for AUIPC PC+imm. BRANCH: compare op with alu_demux=10; bcond is latched into bcond_q.
REQ-026 EXEC next state SHALL be MEM for LOAD/STORE and WB otherwise.
REQ-027 MEM, LOAD: mem_sel=1, load_mdr=1, mem_size and mem_sz_ex_sel from funct3; next WB.
REQ-028 MEM, STORE: mem_sel=1, mem_wr_en=1, size from funct3; PC<-PC+4 in the same cycle (op1_sel=1, op2_sel=10, ADD, alu_demux=01, pc_update=1); next FETCH.
REQ-029 WB SHALL always assert pc_update with alu_demux=01: PC+imm for JAL and taken branches (bcond_q=1), JALR_ADD rs1+imm for JALR, PC+4 otherwise.
REQ-030 WB SHALL assert reg_file_wr_en for all register-writing instructions, with wr_reg_mux_sel=1 only for LOAD; next state FETCH.
REQ-031 Cycle counts SHALL be: LOAD 5; R/I/LUI/AUIPC/JAL/JALR/BRANCH/STORE 4; NOP 3.
REQ-032 Writes to rd=x0 are issued normally; the register file ignores them.

Reset
REQ-033 While rst=0: state=FETCH, bcond_q=0, and every output is forced to 0, including mid-instruction.
REQ-034 The first rising clk after rst goes to 1 SHALL be a FETCH cycle.

Configuration
REQ-035 With CNTL_MC_ILLEGAL_HALT_EN defined, an unrecognised opcode in DECODE SHALL enter a HALT state with all outputs 0 until reset.
REQ-036 Without CNTL_MC_ILLEGAL_HALT_EN, an unrecognised opcode SHALL be treated as a NOP (DECODE->WB, PC+4).

Verification
REQ-037 rst=0 in mid-EXEC -> all outputs 0 immediately; after release, load_ir=1 on the next cycle.
REQ-038 inst=0x002081B3 (ADD x3,x1,x2) -> EXEC alu_ctrl=0, op2_sel=00; WB reg_file_wr_en=1, wr_reg_mux_sel=0, pc_update=1; 4 cycles.
REQ-039 inst=0x0080A283 (LW x5,8(x1)) -> imm=0x00008; MEM load_mdr=1, mem_size=10, mem_sel=1; WB wr_reg_mux_sel=1; 5 cycles.
REQ-040 inst=0x0050A623 (SW x5,12(x1)) -> imm=0x0000C; MEM mem_wr_en=1 with pc_update=1; back to FETCH after 4 cycles.
REQ-041 inst=0x00208863 (BEQ, +16), bcond=1 then 0 -> imm=0x00008, sz_ex_mode=01; WB op2_sel=01 if taken, 10 if not.
REQ-042 inst=0x008000EF (JAL x1,+8) -> imm=0x00004, sz_ex_mode=11; WB reg write and PC<-PC+imm. inst=0xFFFFFFFF -> HALT or NOP per REQ-035/036.
